// File: rtl/age_matrix_arbiter.sv
// Oldest-first arbiter: a registered WIDTH x WIDTH age matrix picks the oldest valid requester,
// and the granted requester is moved to youngest on the following clock edge.
module age_matrix_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         v_vld,
    output logic [WIDTH-1:0]         v_grant,
    output logic [WIDTH*WIDTH-1:0]   vv_matrix
);

    // Flattened matrix: bit [i*WIDTH+j] set means requester i is older than requester j.
    logic [WIDTH*WIDTH-1:0] m_q;
    logic [WIDTH*WIDTH-1:0] m_d;
    logic [WIDTH*WIDTH-1:0] m_rst;
    logic [WIDTH-1:0]       blocked;
    logic                   alloc_en;

    // A requester is blocked when any valid requester is older than it.
    always_comb begin
        blocked = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                if (v_vld[j] && m_q[j*WIDTH+i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        v_grant = v_vld & ~blocked;
    end

    always_comb begin
        m_rst = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                m_rst[i*WIDTH+j] = (i < j);
            end
        end
    end

    // Allocated requesters become younger than every non-allocated one; pairs that are both
    // or neither allocated keep their relative order.
    always_comb begin
        alloc_en = |v_grant;
        m_d      = m_q;
        if (alloc_en) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                for (int unsigned j = 0; j < WIDTH; j++) begin
                    if (i != j) begin
                        if (v_grant[j] && !v_grant[i]) begin
                            m_d[i*WIDTH+j] = 1'b1;
                        end else if (v_grant[i] && !v_grant[j]) begin
                            m_d[i*WIDTH+j] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q <= m_rst;
        end else begin
            m_q <= m_d;
        end
    end

    assign vv_matrix = m_q;

endmodule

// File: tb/tb_age_matrix_arbiter.sv
// Randomized and directed bench for age_matrix_arbiter; reference model keeps the LRU order
// as a plain list of requester indices, oldest first.
module tb_age_matrix_arbiter;

    localparam int W = 4;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     v_vld;
    logic [W-1:0]     v_grant;
    logic [W*W-1:0]   vv_matrix;

    age_matrix_arbiter #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .v_vld    (v_vld),
        .v_grant  (v_grant),
        .vv_matrix(vv_matrix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   vld;
        logic [W-1:0]   grant;
        logic [W*W-1:0] mat;
    } exp_t;

    exp_t sb_q[$];
    int   order[$];
    int   n_total  = 0;
    int   n_passed = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    task automatic check(input string name, input logic [W*W-1:0] act, input logic [W*W-1:0] req);
        n_total++;
        if (act === req) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        order.delete();
        for (int i = 0; i < W; i++) order.push_back(i);
    endtask

    function automatic logic [W-1:0] model_grant(input logic [W-1:0] vld);
        logic [W-1:0] g;
        g = '0;
        for (int p = 0; p < order.size(); p++) begin
            if (vld[order[p]]) begin
                g[order[p]] = 1'b1;
                break;
            end
        end
        return g;
    endfunction

    function automatic logic [W*W-1:0] model_matrix();
        logic [W*W-1:0] m;
        m = '0;
        for (int p = 0; p < order.size(); p++) begin
            for (int q = p + 1; q < order.size(); q++) begin
                m[order[p]*W + order[q]] = 1'b1;
            end
        end
        return m;
    endfunction

    // One cycle of stimulus: drive after the edge, record expectation, then advance the model
    // to the state the DUT will hold after the next edge.
    task automatic step(input logic rst, input logic [W-1:0] vld);
        exp_t e;
        logic [W-1:0] g;
        @(posedge clk);
        #1;
        rst_n = rst;
        v_vld = vld;
        g       = model_grant(vld);
        e.vld   = vld;
        e.grant = g;
        e.mat   = model_matrix();
        sb_q.push_back(e);
        n_pushed++;
        if (!rst) begin
            model_reset();
        end else if (g != '0) begin
            for (int p = 0; p < order.size(); p++) begin
                if (g[order[p]]) begin
                    order.push_back(order[p]);
                    order.delete(p);
                    break;
                end
            end
        end
    endtask

    // Monitor: compares the combinational outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_popped++;
                check("grant", {{(W*W-W){1'b0}}, v_grant}, {{(W*W-W){1'b0}}, e.grant});
                check("matrix", vv_matrix, e.mat);
                ok = (v_vld != '0) ? $onehot(v_grant) : (v_grant == '0);
                check("grant_onehot_iff_vld", {{(W*W-1){1'b0}}, ok}, {{(W*W-1){1'b0}}, 1'b1});
                ok = 1'b1;
                for (int i = 0; i < W; i++) begin
                    if (vv_matrix[i*W+i] !== 1'b0) ok = 1'b0;
                    for (int j = i + 1; j < W; j++) begin
                        if ((vv_matrix[i*W+j] ^ vv_matrix[j*W+i]) !== 1'b1) ok = 1'b0;
                    end
                end
                check("total_order", {{(W*W-1){1'b0}}, ok}, {{(W*W-1){1'b0}}, 1'b1});
            end
        end
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        v_vld = '0;
        // Initial reset edge: matrix is unknown before it, so nothing is recorded.
        @(posedge clk);
        #1;
        model_reset();

        // Reset check and idle.
        step(1'b0, 4'b0000);
        repeat (3) step(1'b1, 4'b0000);
        // Full round robin.
        repeat (5) step(1'b1, 4'b1111);
        // LRU with sparse requests.
        step(1'b0, 4'b0000);
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0011);
        // Single requester, then hold.
        repeat (3) step(1'b1, 4'b0100);
        repeat (4) step(1'b1, 4'b0000);
        // Reset mid-operation.
        step(1'b0, 4'b0000);
        repeat (3) step(1'b1, 4'b1111);
        step(1'b0, 4'b1111);
        repeat (2) step(1'b1, 4'b1111);
        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) != 0), W'($urandom()));
        end
        step(1'b1, 4'b0000);

        cnt = 0;
        while (sb_q.size() > 0 && cnt < 10) begin
            @(posedge clk);
            cnt++;
        end
        check("scoreboard_drained", 32'(n_popped), 32'(n_pushed));
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
